// File: rtl/rom_streamer.sv
// ============================================================================
// Module  : rom_streamer
// Purpose : Bursts consecutive ROM words onto a valid/ready stream, hiding the
//           ROM's one-cycle read latency behind a 2-entry skid buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_streamer #(
  parameter int Data_width = 8,
  parameter int Addr_width = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [Addr_width-1:0] start_addr,
  input  logic [Addr_width:0]   len,
  output logic [Addr_width-1:0] rom_addr,
  input  logic [Data_width-1:0] rom_q,
  output logic [Data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [Addr_width-1:0] r_rom_addr;
  logic [Addr_width:0]   r_issue_cnt;
  logic [Addr_width:0]   r_beat_cnt;
  logic                  r_inflight;
  logic [1:0]            r_cnt;
  logic [Data_width-1:0] r_buf0;
  logic [Data_width-1:0] r_buf1;

  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic [1:0]            w_rem;

  assign w_pop   = (r_cnt != 2'd0) && m_ready;
  // Occupancy counts the word already in flight so the buffer can never overflow.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_issue_cnt != '0) && (w_occ < 3'd2);
  assign w_rem   = r_cnt - {1'b0, w_pop};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rom_addr  <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_cnt       <= 2'd0;
      r_buf0      <= '0;
      r_buf1      <= '0;
    end else begin
      r_inflight <= w_issue;
      r_cnt      <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

      if (w_issue) begin
        r_rom_addr  <= r_rom_addr + Addr_width'(1);
        r_issue_cnt <= r_issue_cnt - 1'b1;
      end

      if (w_pop) begin
        r_buf0     <= r_buf1;
        r_beat_cnt <= r_beat_cnt - 1'b1;
      end

      // Returning word lands behind whatever survives this cycle's pop.
      if (r_inflight) begin
        if (w_rem == 2'd0) begin
          r_buf0 <= rom_q;
        end else begin
          r_buf1 <= rom_q;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              r_state     <= S_RUN;
              r_rom_addr  <= start_addr;
              r_issue_cnt <= len;
              r_beat_cnt  <= len;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_pop && (r_beat_cnt == 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr = r_rom_addr;
  assign m_data   = r_buf0;
  assign m_valid  = (r_cnt != 2'd0);
  assign m_last   = (r_cnt != 2'd0) && (r_beat_cnt == 1);
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_rom_streamer.sv
// ============================================================================
// Module  : tb_rom_streamer
// Purpose : Self-checking bench for rom_streamer with a burst-level model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_streamer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] len;
  logic [2:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [7:0] rom_img [0:7];

  rom_streamer #(.Data_width(8), .Addr_width(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_img[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Burst-level model: expected words per burst, busy/done timeline.
  logic [7:0] exp_d[$];
  logic [2:0] exp_a[$];
  logic       mdl_busy = 1'b0;
  logic       mdl_done = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       chk_dist = 1'b0;
  int         beats = 0;

  always @(negedge clk) begin
    logic       nxt_done;
    logic [2:0] a;
    logic [2:0] diff;
    if (reset) begin
      exp_d.delete();
      exp_a.delete();
      mdl_busy   = 1'b0;
      mdl_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("busy", busy, mdl_busy);
      chk("done", done, mdl_done);
      if (m_valid) begin
        chk("beat_expected", exp_d.size() != 0, 1);
        if (exp_d.size() != 0) begin
          chk("m_data", m_data, exp_d[0]);
          chk("m_last", m_last, exp_d.size() == 1);
          if (chk_dist) begin
            diff = rom_addr - exp_a[0];
            chk("addr_ahead", diff <= 3'd2, 1);
          end
        end
      end
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;

      nxt_done = 1'b0;
      if (mdl_done) begin
        nxt_done = 1'b0;
      end else if (mdl_busy) begin
        if (m_valid && m_ready && exp_d.size() != 0) begin
          void'(exp_d.pop_front());
          void'(exp_a.pop_front());
          beats++;
          if (exp_d.size() == 0) begin
            mdl_busy = 1'b0;
            nxt_done = 1'b1;
          end
        end
      end else if (start) begin
        if (len == 4'd0) begin
          nxt_done = 1'b1;
        end else begin
          mdl_busy = 1'b1;
          for (int i = 0; i < int'(len); i++) begin
            a = start_addr + 3'(i);
            exp_d.push_back(rom_img[a]);
            exp_a.push_back(a);
          end
        end
      end
      mdl_done = nxt_done;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40 && !done; i++) tick();
    chk("done_seen", done, 1);
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  logic [0:5] rdy_pat;
  int         b0;

  initial begin
    rom_img[0] = 8'h80; rom_img[1] = 8'hAA; rom_img[2] = 8'h55; rom_img[3] = 8'h83;
    rom_img[4] = 8'h00; rom_img[5] = 8'h99; rom_img[6] = 8'h81; rom_img[7] = 8'hF0;
    reset = 1'b1; start = 1'b0; start_addr = 3'd0; len = 4'd0; m_ready = 1'b1;
    rdy_pat = 6'b100101;

    tick();
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // Full sweep from 0 with no backpressure.
    start = 1'b1; start_addr = 3'd0; len = 4'd8;
    tick();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_e0_valid", m_valid, 0);
    tick();
    chk("t1_e1_valid", m_valid, 0);
    tick();
    chk("t1_first_valid", m_valid, 1);
    chk("t1_first_data", m_data, 8'h80);
    chk("t1_first_last", m_last, 0);
    repeat (7) tick();
    chk("t1_last_data", m_data, 8'hF0);
    chk("t1_last_flag", m_last, 1);
    tick();
    chk("t1_done", done, 1);
    chk("t1_after_valid", m_valid, 0);
    tick();
    chk("t1_done_clear", done, 0);

    // Wrap 7 -> 0.
    start = 1'b1; start_addr = 3'd6; len = 4'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t2_first_data", m_data, 8'h81);
    repeat (3) tick();
    chk("t2_last_data", m_data, 8'hAA);
    chk("t2_last_flag", m_last, 1);
    tick();
    chk("t2_done", done, 1);
    tick();

    // Backpressure pattern.
    b0 = beats;
    chk_dist = 1'b1;
    start = 1'b1; start_addr = 3'd1; len = 4'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_ready = rdy_pat[i];
      tick();
    end
    m_ready = 1'b1;
    wait_done();
    chk_dist = 1'b0;
    chk("t3_beats", beats - b0, 3);

    // Zero-length burst.
    start = 1'b1; start_addr = 3'd2; len = 4'd0;
    tick();
    start = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", m_valid, 0);
    tick();
    chk("t4_done_clear", done, 0);
    chk("t4_busy2", busy, 0);
    tick();

    // Start while busy is ignored.
    b0 = beats;
    start = 1'b1; start_addr = 3'd0; len = 4'd2;
    tick();
    start_addr = 3'd5; len = 4'd3;
    tick(); tick();
    start = 1'b0;
    wait_done();
    chk("t5_beats", beats - b0, 2);
    tick();

    // Reset mid-burst with the buffer full.
    m_ready = 1'b0;
    start = 1'b1; start_addr = 3'd0; len = 4'd8;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t6_pre_valid", m_valid, 1);
    chk("t6_pre_data", m_data, 8'h80);
    #2 reset = 1'b1;
    #1 chk_all_zero("midreset");
    tick();
    reset = 1'b0;
    m_ready = 1'b1;
    tick();
    start = 1'b1; start_addr = 3'd3; len = 4'd1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t6_valid", m_valid, 1);
    chk("t6_data", m_data, 8'h83);
    chk("t6_last", m_last, 1);
    tick();
    chk("t6_done", done, 1);
    tick(); tick();

    chk("model_drained", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
